// File: rtl/pipe_collide_score.sv
// Collision/pass detection, BCD score and round FSM for the pipe game.
// Optional best-score register enabled by defining HIGH_SCORE_EN.
module pipe_collide_score #(
    parameter int BIRD_X       = 160,
    parameter int BIRD_W       = 16,
    parameter int BIRD_H       = 16,
    parameter int PIPE_W       = 60,
    parameter int GAP_H        = 120,
    parameter int SCREEN_H     = 480,
    parameter int DEATH_TICKS  = 30,
    parameter int SCORE_DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      start,
    input  logic [9:0]                pipe_x,
    input  logic [9:0]                gap_y,
    input  logic [9:0]                bird_y,
    output logic                      freeze,
    output logic                      round_rst,
    output logic                      game_over,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic                      score_pulse,
    output logic [1:0]                state,
    output logic [4*SCORE_DIGITS-1:0] hi_score_bcd
);
    localparam int SW    = 4 * SCORE_DIGITS;
    localparam int CNT_W = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;

    localparam logic [10:0] L_BIRD_X   = 11'(BIRD_X);
    localparam logic [10:0] L_BIRD_R   = 11'(BIRD_X + BIRD_W);
    localparam logic [10:0] L_BIRD_H   = 11'(BIRD_H);
    localparam logic [10:0] L_PIPE_W   = 11'(PIPE_W);
    localparam logic [10:0] L_HALF_GAP = 11'(GAP_H / 2);
    localparam logic [10:0] L_SCREEN_H = 11'(SCREEN_H);
    localparam logic [CNT_W-1:0] L_CNT_LAST = CNT_W'(DEATH_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [SW-1:0]    r_score, w_score_nx;
    logic             r_pulse, w_pulse_nx;
    logic             r_rr, w_rr_nx;
    logic [9:0]       r_prev_x, w_prev_nx;

    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_is_max(input logic [SW-1:0] v);
        logic m;
        m = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) m = 1'b0;
        end
        return m;
    endfunction

    // Geometry in 11 bits so sums of 10-bit coordinates never wrap.
    logic [10:0] w_px, w_gy, w_by, w_prev, w_gap_top, w_gap_bot, w_bird_bot;
    logic        w_ground, w_h_overlap, w_hit, w_pass;

    assign w_px       = {1'b0, pipe_x};
    assign w_gy       = {1'b0, gap_y};
    assign w_by       = {1'b0, bird_y};
    assign w_prev     = {1'b0, r_prev_x};
    assign w_gap_top  = (w_gy >= L_HALF_GAP) ? (w_gy - L_HALF_GAP) : 11'd0;
    assign w_gap_bot  = w_gy + L_HALF_GAP;
    assign w_bird_bot = w_by + L_BIRD_H;
    assign w_ground   = (w_bird_bot >= L_SCREEN_H);
    assign w_h_overlap = (w_px < L_BIRD_R) && ((w_px + L_PIPE_W) > L_BIRD_X);
    assign w_hit  = w_ground ||
                    (w_h_overlap && ((w_by < w_gap_top) || (w_bird_bot > w_gap_bot)));
    assign w_pass = (w_px <= w_prev) && ((w_prev + L_PIPE_W) > L_BIRD_X) &&
                    ((w_px + L_PIPE_W) <= L_BIRD_X);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_score_nx = r_score;
        w_pulse_nx = 1'b0;
        w_rr_nx    = 1'b0;
        w_prev_nx  = tick ? pipe_x : r_prev_x;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nx = S_PLAY;
            end
            S_PLAY: begin
                if (tick) begin
                    if (w_hit) begin
                        w_state_nx = S_DYING;
                        w_cnt_nx   = '0;
                    end else if (w_pass && !bcd_is_max(r_score)) begin
                        w_score_nx = bcd_inc(r_score);
                        w_pulse_nx = 1'b1;
                    end
                end
            end
            S_DYING: begin
                if (tick) begin
                    if (r_cnt == L_CNT_LAST) w_state_nx = S_OVER;
                    else                     w_cnt_nx   = r_cnt + 1'b1;
                end
            end
            S_OVER: begin
                if (start) begin
                    w_state_nx = S_IDLE;
                    w_score_nx = '0;
                    w_rr_nx    = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_score  <= '0;
            r_pulse  <= 1'b0;
            r_rr     <= 1'b0;
            r_prev_x <= 10'd639;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_score  <= w_score_nx;
            r_pulse  <= w_pulse_nx;
            r_rr     <= w_rr_nx;
            r_prev_x <= w_prev_nx;
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SW-1:0] r_hi;

    // Packed BCD compares in the same order as the decimal values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
        end else if (r_state == S_DYING && w_state_nx == S_OVER && r_score > r_hi) begin
            r_hi <= r_score;
        end
    end

    assign hi_score_bcd = r_hi;
`else
    assign hi_score_bcd = '0;
`endif

    assign state       = r_state;
    assign freeze      = (r_state != S_PLAY);
    assign game_over   = (r_state == S_OVER);
    assign round_rst   = r_rr;
    assign score_pulse = r_pulse;
    assign score_bcd   = r_score;
endmodule

// File: tb/tb_pipe_collide_score.sv
// Directed bench for pipe_collide_score: the driver queues expected outputs,
// a monitor pops and compares them one cycle after each driven cycle.
module tb_pipe_collide_score;
    localparam int EW = 28;  // {state, pulse, round_rst, score[11:0], hi[11:0]}

    logic        clk;
    logic        reset;
    logic        tick;
    logic        start;
    logic [9:0]  pipe_x;
    logic [9:0]  gap_y;
    logic [9:0]  bird_y;
    logic        freeze;
    logic        round_rst;
    logic        game_over;
    logic [11:0] score_bcd;
    logic        score_pulse;
    logic [1:0]  state;
    logic [11:0] hi_score_bcd;

    logic [EW-1:0] exp_q[$];
    logic          mon_en;
    int            n_checks;
    int            n_fail;
    int            e_score;
    int            e_hi;

    pipe_collide_score dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .start        (start),
        .pipe_x       (pipe_x),
        .gap_y        (gap_y),
        .bird_y       (bird_y),
        .freeze       (freeze),
        .round_rst    (round_rst),
        .game_over    (game_over),
        .score_bcd    (score_bcd),
        .score_pulse  (score_pulse),
        .state        (state),
        .hi_score_bcd (hi_score_bcd)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'((v / 100) % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [11:0] exp_hi();
`ifdef HIGH_SCORE_EN
        return to_bcd(e_hi);
`else
        return 12'h000;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // driver tasks
    task automatic step(input bit t, input bit s, input int px, input int gy, input int by,
                        input int est, input bit epulse, input bit err, input int escore);
        logic [1:0] st;
        @(negedge clk);
        tick   = t;
        start  = s;
        pipe_x = px[9:0];
        gap_y  = gy[9:0];
        bird_y = by[9:0];
        st     = est[1:0];
        exp_q.push_back({st, epulse, err, to_bcd(escore), exp_hi()});
        mon_en = 1'b1;
        @(posedge clk);
    endtask

    task automatic quiet();
        @(negedge clk);
        tick   = 1'b0;
        start  = 1'b0;
        mon_en = 1'b0;
    endtask

    // One scoring pass: pipe right of the threshold, then exactly at it.
    task automatic pass_one();
        bit p;
        step(1, 0, 110, 240, 230, 1, 0, 0, e_score);
        p = (e_score < 999);
        if (p) e_score++;
        step(1, 0, 100, 240, 230, 1, p, 0, e_score);
    endtask

    task automatic dying_to_over(input int final_hi);
        step(0, 1, 100, 240, 230, 2, 0, 0, e_score);  // start ignored while dying
        for (int k = 1; k <= 30; k++) begin
            if (k == 30) e_hi = final_hi;
            step(1, 0, 100, 240, 230, (k == 30) ? 3 : 2, 0, 0, e_score);
        end
        step(0, 0, 100, 240, 230, 3, 0, 0, e_score);
        e_score = 0;
        step(0, 1, 100, 240, 230, 0, 0, 1, e_score);
        step(0, 0, 100, 240, 230, 0, 0, 0, e_score);
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        if (mon_en) begin
            logic [EW-1:0] e;
            logic [EW-1:0] g;
            logic          e_fz;
            logic          e_go;
            #2;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: got output with no expectation queued, required one queued");
            end else begin
                e    = exp_q.pop_front();
                g    = {state, score_pulse, round_rst, score_bcd, hi_score_bcd};
                e_fz = (e[27:26] != 2'd1);
                e_go = (e[27:26] == 2'd3);
                if (g !== e || freeze !== e_fz || game_over !== e_go) begin
                    n_fail++;
                    $display("FAIL scoreboard: got st=%0d fz=%0b go=%0b pulse=%0b rr=%0b score=%h hi=%h, required st=%0d fz=%0b go=%0b pulse=%0b rr=%0b score=%h hi=%h",
                             g[27:26], freeze, game_over, g[25], g[24], g[23:12], g[11:0],
                             e[27:26], e_fz, e_go, e[25], e[24], e[23:12], e[11:0]);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        e_score  = 0;
        e_hi     = 0;
        mon_en   = 1'b0;
        reset    = 1'b0;
        tick     = 1'b0;
        start    = 1'b0;
        pipe_x   = 10'd300;
        gap_y    = 10'd240;
        bird_y   = 10'd230;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_freeze", 32'(freeze), 32'd1);
        chk("reset_score", 32'(score_bcd), 32'h000);
        chk("reset_outputs", {29'd0, round_rst, game_over, score_pulse}, 32'd0);
        chk("reset_hi", 32'(hi_score_bcd), 32'h000);

        // Round 1: play, one pass, wrap, then hit+pass on same tick.
        step(0, 1, 300, 240, 230, 1, 0, 0, 0);
        step(1, 0, 170, 240, 230, 1, 0, 0, 0);
        step(0, 0, 170, 240, 170, 1, 0, 0, 0);  // would hit, but no tick
        pass_one();
        step(0, 0, 100, 240, 230, 1, 0, 0, e_score);
        step(1, 0, 0, 240, 230, 1, 0, 0, e_score);
        step(1, 0, 639, 240, 230, 1, 0, 0, e_score);
        step(1, 0, 110, 240, 230, 1, 0, 0, e_score);
        step(1, 0, 100, 240, 464, 2, 0, 0, e_score);  // ground and pass: hit wins
        dying_to_over(1);

        // Round 2: gap-top hit, reset on the 12th dying tick.
        step(0, 1, 100, 240, 230, 1, 0, 0, 0);
        step(1, 0, 170, 240, 230, 1, 0, 0, 0);
        step(1, 0, 170, 240, 170, 2, 0, 0, 0);
        for (int k = 1; k <= 11; k++) step(1, 0, 100, 240, 230, 2, 0, 0, 0);
        @(negedge clk);
        mon_en = 1'b0;
        tick   = 1'b1;
        reset  = 1'b0;
        #1;
        e_hi = 0;
        chk("async_reset_state", 32'(state), 32'd0);
        chk("async_reset_round_rst", 32'(round_rst), 32'd0);
        chk("async_reset_freeze", 32'(freeze), 32'd1);
        chk("async_reset_hi", 32'(hi_score_bcd), 32'h000);
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Round 3: tick+start in IDLE, count to saturation, die, restart.
        step(1, 1, 100, 240, 464, 1, 0, 0, 0);
        while (e_score < 999) pass_one();
        pass_one();  // saturated: no pulse, stays 999
        step(1, 0, 170, 240, 170, 2, 0, 0, e_score);
        dying_to_over(999);
        quiet();

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_collide_score.md
Name: pipe_collide_score

Overview:
- Downstream consumer of the pipe mover. Each frame tick it compares pipe_x/gap_y against the bird position and detects collisions and pipe passes.
- Maintains a BCD score and runs the round state machine.
- Drives freeze and a per-round restart pulse back to the pipe mover and bird logic.

Parameters:
- BIRD_X, 160: fixed bird left column (px)
- BIRD_W, 16: bird width (px)
- BIRD_H, 16: bird height (px)
- PIPE_W, 60: pipe width (px); pipe spans pipe_x..pipe_x+PIPE_W-1
- GAP_H, 120: gap height; gap centred on gap_y
- SCREEN_H, 480: ground line (px)
- DEATH_TICKS, 30: ticks spent in DYING before OVER
- SCORE_DIGITS, 3: BCD digits of score

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low (0 = reset)
- tick  in  1  one-cycle frame strobe; all game evaluation happens only on tick cycles
- start  in  1  one-cycle start/flap request
- pipe_x  in  10  pipe left edge, from pipe mover
- gap_y  in  10  gap centre, from pipe mover
- bird_y  in  10  bird top row
- freeze  out  1  halts pipe/bird motion
- round_rst  out  1  one-cycle active-high pulse; re-initialises pipe mover and bird
- game_over  out  1  high in OVER
- score_bcd  out  4*SCORE_DIGITS  score, digit 0 = LSD
- score_pulse  out  1  one-cycle pulse per point
- state  out  2  IDLE=0, PLAY=1, DYING=2, OVER=3
- hi_score_bcd  out  4*SCORE_DIGITS  best score (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, freeze=1, round_rst=0, game_over=0, score=0, score_pulse=0, death counter=0, prev_x=639, hi_score=0.
- Reset acts immediately in any state, including mid-DYING.
- All comparisons use 11-bit unsigned arithmetic; no wrap.
  - gap_top = gap_y - GAP_H/2, saturating at 0.
  - gap_bot = gap_y + GAP_H/2.
  - h_overlap = (pipe_x < BIRD_X+BIRD_W) && (pipe_x+PIPE_W > BIRD_X).
  - hit = ground || (h_overlap && (bird_y < gap_top || bird_y+BIRD_H > gap_bot)).
  - ground = bird_y+BIRD_H >= SCREEN_H.
  - pass = (pipe_x <= prev_x) && (prev_x+PIPE_W > BIRD_X) && (pipe_x+PIPE_W <= BIRD_X).
  - pipe_x > prev_x (wrap 0->639) never scores.
- prev_x <= pipe_x on every tick, in all states.
- Latency: inputs sampled on a tick cycle N produce registered outputs at cycle N+1.
- FSM:
  - IDLE: freeze=1. start -> PLAY.
  - PLAY: freeze=0. Hit on tick -> DYING, freeze=1, counter cleared. Otherwise pass on tick -> score+1, score_pulse=1 for one cycle. start is ignored.
  - DYING: freeze=1. Counter increments per tick; on the tick where it reaches DEATH_TICKS-1 -> OVER.
  - OVER: game_over=1, freeze=1. start -> round_rst=1 for exactly one cycle, score cleared -> IDLE.
- Hit and pass on the same tick: hit wins, no score.
- Score is a BCD ripple increment; it saturates at all nines (999 stays 999, no pulse).
- tick and start in the same cycle in IDLE: transition occurs; no evaluation until the next tick.
- Non-tick cycles: state, score and counter hold; only start transitions act.

Optional Feature:
- Macro HIGH_SCORE_EN.
- Defined: hi_score register. On the cycle of entering OVER, if score > hi_score then hi_score <= score. hi_score is cleared only by reset, not by round_rst.
- Undefined: hi_score_bcd is tied to 0 and no register is inferred.

Test Plan:
- Reset low 3 cycles, release -> state=0, freeze=1, score=000. Pulse start -> next cycle state=1, freeze=0.
- PLAY, gap_y=240 (gap 180..300), pipe_x=170, bird_y=230, tick -> no hit. Repeat with bird_y=170 -> next cycle state=2, freeze=1.
- PLAY, bird_y=230, gap_y=240, tick with pipe_x=110 then tick with pipe_x=100 -> score_pulse once, score=001.
- Preload score via passes to 009, one more pass -> 010. At 999, pass -> stays 999, no pulse.
- bird_y=464, tick -> DYING. 30 ticks -> OVER, game_over=1. start -> round_rst high exactly 1 cycle, score=000, state=0. With HIGH_SCORE_EN, hi_score holds the prior score.
- pipe_x 0 -> 639 tick with bird in gap -> no score. Assert reset during DYING tick 12 -> IDLE at once, round_rst=0.
